// File: rtl/exmem_datapath.sv
// EX/MEM datapath slice: ALU-control decode, a registered 32-bit ALU and a
// word-addressed data memory with asynchronous read and synchronous write.
module exmem_datapath #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  output logic [31:0] alu_out,
  output logic        alu_zero,
  input  logic [5:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [2:0]  alu_ctrl_c;
  logic [31:0] alu_out_d, alu_out_q;
  logic        alu_zero_d, alu_zero_q;

  // LW/SW/ADDI, jumps and any unknown opcode all fall through to ADD.
  always_comb begin
    alu_ctrl_c = ALU_ADD;
    if (opcode == OP_RTYPE) begin
      case (funct)
        6'h20, 6'h21: alu_ctrl_c = ALU_ADD;
        6'h22, 6'h23: alu_ctrl_c = ALU_SUB;
        6'h24:        alu_ctrl_c = ALU_AND;
        6'h25:        alu_ctrl_c = ALU_OR;
        6'h26:        alu_ctrl_c = ALU_XOR;
        6'h27:        alu_ctrl_c = ALU_NOR;
        6'h2A:        alu_ctrl_c = ALU_SLT;
        default:      alu_ctrl_c = ALU_ADD;
      endcase
    end else if (opcode == OP_BEQ) begin
      alu_ctrl_c = ALU_SUB;
    end
  end

  always_comb begin
    alu_out_d = 32'h0;
    case (alu_ctrl_c)
      ALU_AND: alu_out_d = alu_a & alu_b;
      ALU_OR:  alu_out_d = alu_a | alu_b;
      ALU_ADD: alu_out_d = alu_a + alu_b;
      ALU_XOR: alu_out_d = alu_a ^ alu_b;
      ALU_NOR: alu_out_d = ~(alu_a | alu_b);
      ALU_SUB: alu_out_d = alu_a - alu_b;
      ALU_SLT: alu_out_d = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_out_d = 32'h0;
    endcase
    alu_zero_d = (alu_out_d == 32'h0);
  end

  // Reset value keeps alu_zero consistent with the cleared result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_out_q  <= 32'h0;
      alu_zero_q <= 1'b1;
    end else begin
      alu_out_q  <= alu_out_d;
      alu_zero_q <= alu_zero_d;
    end
  end

  assign alu_ctrl = alu_ctrl_c;
  assign alu_out  = alu_out_q;
  assign alu_zero = alu_zero_q;

  logic [31:0]   mem_q [DEPTH] = '{default: 32'h0};
  logic [AW-1:0] mem_idx;
  logic          wr_en_d;
  logic          unused_addr_bits;

  // Byte-offset and upper address bits are dropped, so addresses wrap.
  always_comb begin
    mem_idx = mem_addr[AW+1:2];
    wr_en_d = (mem_op == OP_SW);
  end

  assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

  // Deliberately outside the reset domain: contents survive reset and
  // stores are accepted while reset is high.
  always_ff @(posedge clock) begin
    if (wr_en_d) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

  assign mem_rdata = (mem_op == OP_LW) ? mem_q[mem_idx] : 32'h0;

endmodule

// File: tb/tb_exmem_datapath.sv
// Directed bench for exmem_datapath: decode/ALU vector table plus hand-written
// sequences for reset, memory wrap and read-around-write behaviour.
module tb_exmem_datapath;

  logic        clock;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic [5:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  exmem_datapath dut (
    .clock     (clock),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  exp_ctrl;
    logic [31:0] exp_out;
    logic        exp_zero;
  } vec_t;

  vec_t vecs [17];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive_alu(input logic [5:0] op, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b);
    opcode = op;
    funct  = fn;
    alu_a  = a;
    alu_b  = b;
  endtask

  task automatic drive_mem(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd);
    mem_op    = op;
    mem_addr  = addr;
    mem_wdata = wd;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0]  = '{OP_R,    6'h22, 32'd3,        32'd5,        3'b110, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{OP_R,    6'h2A, 32'hFFFFFFFF, 32'd1,        3'b111, 32'd1,        1'b0};
    vecs[2]  = '{OP_R,    6'h2A, 32'd1,        32'hFFFFFFFF, 3'b111, 32'd0,        1'b1};
    vecs[3]  = '{OP_LW,   6'h00, 32'd10,       32'd4,        3'b010, 32'd14,       1'b0};
    vecs[4]  = '{OP_BEQ,  6'h00, 32'd7,        32'd7,        3'b110, 32'd0,        1'b1};
    vecs[5]  = '{OP_R,    6'h08, 32'd2,        32'd3,        3'b010, 32'd5,        1'b0};
    vecs[6]  = '{OP_JAL,  6'h22, 32'd1,        32'd1,        3'b010, 32'd2,        1'b0};
    vecs[7]  = '{OP_R,    6'h20, 32'hFFFFFFFF, 32'd1,        3'b010, 32'd0,        1'b1};
    vecs[8]  = '{OP_R,    6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h00F000F0, 1'b0};
    vecs[9]  = '{OP_R,    6'h25, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b001, 32'hFFF0FFF0, 1'b0};
    vecs[10] = '{OP_R,    6'h26, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b011, 32'hFF00FF00, 1'b0};
    vecs[11] = '{OP_R,    6'h27, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b100, 32'h000F000F, 1'b0};
    vecs[12] = '{OP_R,    6'h21, 32'd100,      32'd200,      3'b010, 32'd300,      1'b0};
    vecs[13] = '{OP_R,    6'h23, 32'd0,        32'd1,        3'b110, 32'hFFFFFFFF, 1'b0};
    vecs[14] = '{OP_ADDI, 6'h24, 32'h80000000, 32'h80000000, 3'b010, 32'd0,        1'b1};
    vecs[15] = '{OP_SW,   6'h2A, 32'd8,        32'd9,        3'b010, 32'd17,       1'b0};
    vecs[16] = '{OP_R,    6'h00, 32'h7FFFFFFF, 32'h1,        3'b010, 32'h80000000, 1'b0};

    reset = 1'b1;
    drive_alu(OP_R, 6'h20, 32'd0, 32'd0);
    drive_mem(OP_R, 32'd0, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    check32("reset_alu_out", alu_out, 32'h0);
    check32("reset_alu_zero", {31'b0, alu_zero}, 32'd1);
    reset = 1'b0;

    // Decode and ALU vector table
    foreach (vecs[i]) begin
      drive_alu(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
      #1;
      check32($sformatf("ctrl_v%0d", i), {29'b0, alu_ctrl}, {29'b0, vecs[i].exp_ctrl});
      tick();
      check32($sformatf("out_v%0d", i), alu_out, vecs[i].exp_out);
      check32($sformatf("zero_v%0d", i), {31'b0, alu_zero}, {31'b0, vecs[i].exp_zero});
    end

    // Asynchronous reset while alu_out is nonzero
    drive_alu(OP_R, 6'h20, 32'd40, 32'd2);
    tick();
    check32("pre_reset_out", alu_out, 32'd42);
    #3;
    reset = 1'b1;
    #1;
    check32("async_reset_out", alu_out, 32'h0);
    check32("async_reset_zero", {31'b0, alu_zero}, 32'd1);
    tick();
    check32("held_reset_out", alu_out, 32'h0);
    #2;
    reset = 1'b0;
    drive_alu(OP_R, 6'h20, 32'd5, 32'd7);
    #1;
    check32("post_reset_hold", alu_out, 32'h0);
    tick();
    check32("post_reset_add", alu_out, 32'd12);
    check32("post_reset_zero", {31'b0, alu_zero}, 32'd0);

    // Memory: zero init, store/load, offset and wrap, gated read
    drive_mem(OP_LW, 32'h40, 32'h0);
    #1;
    check32("mem_init_zero", mem_rdata, 32'h0);
    drive_mem(OP_SW, 32'h10, 32'hDEADBEEF);
    drive_alu(OP_R, 6'h22, 32'd9, 32'd4);
    #1;
    check32("sw_rdata_gated", mem_rdata, 32'h0);
    tick();
    check32("ex_parallel_sub", alu_out, 32'd5);
    drive_mem(OP_LW, 32'h13, 32'h0);
    #1;
    check32("lw_offset_ignored", mem_rdata, 32'hDEADBEEF);
    drive_mem(OP_LW, 32'h1010, 32'h0);
    #1;
    check32("lw_wrap", mem_rdata, 32'hDEADBEEF);
    drive_mem(OP_R, 32'h10, 32'h0);
    #1;
    check32("non_lw_zero", mem_rdata, 32'h0);
    drive_mem(OP_LW, 32'h14, 32'h0);
    #1;
    check32("neighbour_word", mem_rdata, 32'h0);

    // Same word: old value until the store edge, new value after it
    drive_mem(OP_LW, 32'h10, 32'h0);
    #1;
    check32("rdw_old", mem_rdata, 32'hDEADBEEF);
    drive_mem(OP_SW, 32'h10, 32'h12345678);
    tick();
    drive_mem(OP_LW, 32'h10, 32'h0);
    #1;
    check32("rdw_new", mem_rdata, 32'h12345678);

    // Memory survives reset; stores during reset still land
    reset = 1'b1;
    #1;
    check32("mem_during_reset", mem_rdata, 32'h12345678);
    drive_mem(OP_SW, 32'h20, 32'hCAFEF00D);
    tick();
    drive_mem(OP_LW, 32'h20, 32'h0);
    #1;
    check32("sw_in_reset", mem_rdata, 32'hCAFEF00D);
    reset = 1'b0;
    drive_mem(OP_LW, 32'h10, 32'h0);
    #1;
    check32("mem_after_reset", mem_rdata, 32'h12345678);
    check32("alu_after_mem_reset", alu_out, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
